// File: rtl/fp_pkg.sv
// Shared constants for the normalise/round pipeline: default widths,
// mantissa bit positions, the exponent ceiling and the flag layout.
package fp_pkg;

  localparam int MAN_W_DEF = 28;
  localparam int EXP_W_DEF = 8;
  localparam int CNT_W_DEF = 5;

  // Bit positions inside the unnormalised mantissa
  localparam int CARRY  = 27;
  localparam int HIDDEN = 26;
  localparam int GUARD  = 2;
  localparam int ROUND  = 1;
  localparam int STICKY = 0;

  // First biased exponent that no longer fits a finite single
  localparam int EXP_MAX = 255;

  // Flag vector layout {overflow, underflow, inexact}
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } flags_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even and IEEE single packing (combinational, stage 2).
// Takes a normalised mantissa (hidden bit at HIDDEN) and a signed exponent.
// Build option FP_NORM_SUBNORMAL_EN: when defined, tiny results are
// denormalised and rounded; otherwise they flush to a signed zero.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic                    sign_i,
  input  logic                    zero_i,
  input  logic [MAN_W-1:0]        man_i,
  input  logic signed [EXP_W+1:0] exp_i,
  output logic [31:0]             result_o,
  output flags_t                  flags_o
);

  localparam logic signed [EXP_W+1:0] EXP_MAX_S = (EXP_W+2)'(EXP_MAX);

  logic                    tiny;
  logic [MAN_W-1:0]        man_a;
  logic                    lsb, grd, rnd, stk, inc, inexact;
  logic [24:0]             sum;
  logic signed [EXP_W+1:0] exp_r;
  logic                    unused;

  // Exponent at or below zero cannot be represented as a normal number
  assign tiny = exp_i[EXP_W+1] | (exp_i == '0);

`ifdef FP_NORM_SUBNORMAL_EN
  logic [EXP_W+1:0] shamt;
  logic [MAN_W-1:0] lost_mask;

  // Denormalise: shift right by 1-exp, folding every lost bit into sticky
  always_comb begin
    shamt     = '0;
    lost_mask = '0;
    man_a     = man_i;
    if (tiny) begin
      shamt     = {{(EXP_W+1){1'b0}}, 1'b1} - $unsigned(exp_i);
      lost_mask = ~({MAN_W{1'b1}} << shamt);
      man_a     = (man_i >> shamt) | {{(MAN_W-1){1'b0}}, |(man_i & lost_mask)};
    end
  end
`else
  assign man_a = man_i;
`endif

  assign lsb     = man_a[GUARD+1];
  assign grd     = man_a[GUARD];
  assign rnd     = man_a[ROUND];
  assign stk     = man_a[STICKY];
  assign inc     = grd & (rnd | stk | lsb);
  assign inexact = grd | rnd | stk;
  assign sum     = {1'b0, man_a[HIDDEN:GUARD+1]} + {24'b0, inc};
  // A carry out of the hidden bit bumps the exponent; fraction becomes zero
  assign exp_r   = exp_i + $signed({{(EXP_W+1){1'b0}}, sum[24]});

  // Carry bit is always clear after normalisation; sum[23] is the hidden bit
  assign unused  = ^{man_a[CARRY], sum[23]};

  // Select zero / tiny / overflow / normal packing
  always_comb begin
    result_o = {sign_i, 31'b0};
    flags_o  = '0;
    if (zero_i) begin
      result_o = {sign_i, 31'b0};
    end else if (tiny) begin
`ifdef FP_NORM_SUBNORMAL_EN
      // Rounding up into bit 23 naturally yields exponent field 1
      result_o    = {sign_i, 7'b0, sum[23:0]};
      flags_o.unf = inexact;
      flags_o.inx = inexact;
`else
      flags_o.unf = 1'b1;
      flags_o.inx = 1'b1;
`endif
    end else if (exp_r >= EXP_MAX_S) begin
      result_o    = {sign_i, 8'hFF, 23'b0};
      flags_o.ovf = 1'b1;
      flags_o.inx = 1'b1;
    end else begin
      result_o    = {sign_i, exp_r[7:0], sum[24] ? 23'b0 : sum[22:0]};
      flags_o.inx = inexact;
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage normalise / round-and-pack pipeline producing IEEE singles.
// S1 normalises using the supplied leading-zero count, S2 rounds (RNE)
// and packs. A single advance signal stalls the whole pipe on backpressure.
// Build option FP_NORM_SUBNORMAL_EN selects gradual underflow in S2.
module fp_normalize_round
  import fp_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_man,
  input  logic [CNT_W-1:0] in_lz,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags
);

  localparam int XW = EXP_W + 2;

  logic             advance;
  logic [1:0]       vld_pipe_q;     // [0] S1 holds an operand, [1] output valid
  logic [CNT_W-1:0] lz_m1;
  logic [MAN_W-1:0] s1_man_d, s1_man_q;
  logic [XW-1:0]    s1_exp_d, s1_exp_q;
  logic             s1_sign_q, s1_zero_q;
  logic [31:0]      rnd_result;
  flags_t           rnd_flags;
  logic [31:0]      out_result_q;
  logic [2:0]       out_flags_q;

  assign advance    = !vld_pipe_q[1] || out_ready;
  assign in_ready   = advance;
  assign out_valid  = vld_pipe_q[1];
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

  assign lz_m1 = in_lz - {{(CNT_W-1){1'b0}}, 1'b1};

  // S1 normalise: lz==0 means the carry bit is set, so shift right one
  always_comb begin
    s1_man_d = in_man << lz_m1;
    s1_exp_d = {2'b00, in_exp} - {{(XW-CNT_W){1'b0}}, lz_m1};
    if (in_lz == '0) begin
      s1_man_d = {1'b0, in_man[MAN_W-1:2], in_man[1] | in_man[0]};
      s1_exp_d = {2'b00, in_exp} + {{(XW-1){1'b0}}, 1'b1};
    end
  end

  // Stage valid bits; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst)          vld_pipe_q <= '0;
    else if (advance) vld_pipe_q <= {vld_pipe_q[0], in_valid};
  end

  // S1 payload registers
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_man_q  <= s1_man_d;
      s1_exp_q  <= s1_exp_d;
      s1_sign_q <= in_sign;
      s1_zero_q <= in_zero;
    end
  end

  fp_round_rne #(
    .MAN_W (MAN_W),
    .EXP_W (EXP_W)
  ) u_round (
    .sign_i   (s1_sign_q),
    .zero_i   (s1_zero_q),
    .man_i    (s1_man_q),
    .exp_i    ($signed(s1_exp_q)),
    .result_o (rnd_result),
    .flags_o  (rnd_flags)
  );

  // S2 output registers, loaded only from a valid S1 operand
  always_ff @(posedge clk) begin
    if (rst) begin
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (advance && vld_pipe_q[0]) begin
      out_result_q <= rnd_result;
      out_flags_q  <= rnd_flags;
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed vector table, reset-in-flight
// sequence, and randomized streams with random backpressure checked
// against an exact-arithmetic rounding model.
`timescale 1ns/1ps
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_man = '0;
  logic [4:0]  in_lz = '0;
  logic        in_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_normalize_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_man     (in_man),
    .in_lz      (in_lz),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  ex;
    logic [27:0] man;
    logic [4:0]  lz;
    logic        zero;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [27:0] m,
                              input logic [4:0] lz, input logic z,
                              input logic [31:0] r, input logic [2:0] f);
    vec_t v;
    v.sign = s; v.ex = e; v.man = m; v.lz = lz; v.zero = z; v.res = r; v.flg = f;
    return v;
  endfunction

  // Exact RNE of man * 2^(ex-153) into single precision; returns {result, flags}
  function automatic logic [34:0] ref_model(input logic s, input logic [7:0] ex,
                                            input logic [27:0] m, input logic z);
    int p, e, k, sh;
    longint unsigned q, rem, half;
    logic inx;
    if (z) return {s, 34'b0};
    p = 27;
    while (p > 0 && !m[p]) p--;
    e = int'(ex) + p - 26;
    k = 23 - p;
`ifdef FP_NORM_SUBNORMAL_EN
    if (e <= 0) k = int'(ex) - 4;
`else
    if (e <= 0) return {s, 31'b0, 3'b011};
`endif
    q = longint'(m);
    inx = 1'b0;
    if (k >= 0) q = q << k;
    else begin
      sh   = -k;
      rem  = q & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      q    = q >> sh;
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q++;
    end
    if (e <= 0) return {s, 31'(q), 1'b0, inx, inx};
    if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e++; end
    if (e >= 255) return {s, 8'hFF, 23'b0, 3'b101};
    return {s, 8'(e), q[22:0], 2'b00, inx};
  endfunction

  task automatic gen_op(output logic s, output logic [7:0] e, output logic [27:0] m,
                        output logic [4:0] lz, output logic z);
    int p;
    logic [27:0] one;
    one = 28'd1;
    s = 1'($urandom);
    e = 8'($urandom);
    if ($urandom_range(3, 0) == 0)
      e = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(3, 0)) : 8'(252 + $urandom_range(3, 0));
    z = 1'b0;
    m = '0;
    lz = 5'd28;
    if ($urandom_range(15, 0) == 0) begin z = 1'b1; return; end
    case ($urandom_range(3, 0))
      0:       p = 27;
      1, 2:    p = 26;
      default: p = $urandom_range(26, 0);
    endcase
    m = 28'($urandom);
    m = (m & ((one << p) - one)) | (one << p);
    if (p == 26 && $urandom_range(3, 0) == 0) m = m | 28'h3FFFFF8;
    lz = 5'(27 - p);
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] m,
                       input logic [4:0] lz, input logic z);
    in_sign = s; in_exp = e; in_man = m; in_lz = lz; in_zero = z;
  endtask

  // Random stream with random backpressure, scoreboarded in order
  task automatic run_stream(input string tag, input int n, input int rdy_pct, input bit dense);
    logic [34:0] q[$];
    logic [34:0] want;
    int sent, got, cyc;
    logic pend, stall;
    logic [31:0] h_res;
    logic [2:0]  h_flg;
    logic s, z;
    logic [7:0] e;
    logic [27:0] m;
    logic [4:0] lz;
    sent = 0; got = 0; cyc = 0; pend = 1'b0; stall = 1'b0;
    h_res = '0; h_flg = '0;
    while (got < n && cyc < 40 * n + 100) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        check($sformatf("%s hold valid", tag), 64'(out_valid), 64'd1);
        check($sformatf("%s hold data", tag), {29'b0, out_result, out_flags}, {29'b0, h_res, h_flg});
      end
      out_ready = ($urandom_range(99, 0) < rdy_pct);
      if (!pend) in_valid = 1'b0;
      if (!pend && sent < n && (dense || $urandom_range(3, 0) != 0)) begin
        gen_op(s, e, m, lz, z);
        drive(s, e, m, lz, z);
        in_valid = 1'b1;
        pend = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        check($sformatf("%s output expected", tag), 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          want = q.pop_front();
          check($sformatf("%s result #%0d", tag, got), {29'b0, out_result, out_flags}, {29'b0, want});
        end
        got++;
      end
      stall = out_valid && !out_ready;
      h_res = out_result;
      h_flg = out_flags;
      if (in_valid && in_ready) begin
        q.push_back(ref_model(in_sign, in_exp, in_man, in_zero));
        sent++;
        pend = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check($sformatf("%s delivered", tag), 64'(got), 64'(n));
    check($sformatf("%s sent", tag), 64'(sent), 64'(n));
    check($sformatf("%s leftover", tag), 64'(q.size()), 64'd0);
    if (dense) check($sformatf("%s cycles", tag), 64'(cyc), 64'(n + 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(1'b0, 8'd127, 28'h4000000, 5'd1, 1'b0, 32'h3F800000, 3'b000);
    vt[1]  = mk(1'b0, 8'd127, 28'h8000000, 5'd0, 1'b0, 32'h40000000, 3'b000);
    vt[2]  = mk(1'b0, 8'd254, 28'h8000000, 5'd0, 1'b0, 32'h7F800000, 3'b101);
    vt[3]  = mk(1'b0, 8'd127, 28'h400000C, 5'd1, 1'b0, 32'h3F800002, 3'b001);
    vt[4]  = mk(1'b0, 8'd127, 28'h4000004, 5'd1, 1'b0, 32'h3F800000, 3'b001);
    vt[5]  = mk(1'b1, 8'd90,  28'h0000000, 5'd28, 1'b1, 32'h80000000, 3'b000);
`ifdef FP_NORM_SUBNORMAL_EN
    vt[6]  = mk(1'b0, 8'd1,   28'h1000000, 5'd3, 1'b0, 32'h00200000, 3'b000);
`else
    vt[6]  = mk(1'b0, 8'd1,   28'h1000000, 5'd3, 1'b0, 32'h00000000, 3'b011);
`endif
    vt[7]  = mk(1'b0, 8'd127, 28'h7FFFFFC, 5'd1, 1'b0, 32'h40000000, 3'b001);
    vt[8]  = mk(1'b0, 8'd254, 28'h7FFFFFC, 5'd1, 1'b0, 32'h7F800000, 3'b101);
    vt[9]  = mk(1'b1, 8'd130, 28'h4000000, 5'd1, 1'b0, 32'hC1000000, 3'b000);
    vt[10] = mk(1'b0, 8'd128, 28'h2000000, 5'd2, 1'b0, 32'h3F800000, 3'b000);
    vt[11] = mk(1'b0, 8'd127, 28'h8000001, 5'd0, 1'b0, 32'h40000000, 3'b001);

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_result", 64'(out_result), 64'd0);
    check("reset out_flags", 64'(out_flags), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);

    // Directed vectors: one at a time, exact 2-cycle latency
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vt[i].sign, vt[i].ex, vt[i].man, vt[i].lz, vt[i].zero);
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d early valid", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      check($sformatf("vec%0d latency", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d result", i), 64'(out_result), 64'(vt[i].res));
      check($sformatf("vec%0d flags", i), 64'(out_flags), 64'(vt[i].flg));
    end

    // Reset with two operands inside the pipe, output stalled
    @(negedge clk);
    out_ready = 1'b0;
    drive(vt[0].sign, vt[0].ex, vt[0].man, vt[0].lz, vt[0].zero);
    in_valid = 1'b1;
    @(negedge clk);
    drive(vt[1].sign, vt[1].ex, vt[1].man, vt[1].lz, vt[1].zero);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("flight stalled valid", 64'(out_valid), 64'd1);
    check("flight stalled in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check("flight reset valid", 64'(out_valid), 64'd0);
    check("flight reset result", 64'(out_result), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("flight drained %0d", i), 64'(out_valid), 64'd0);
    end

    // Streams
    run_stream("stream8", 8, 50, 1'b0);
    run_stream("dense", 40, 100, 1'b1);
    run_stream("random", 300, 65, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
